// File: rtl/gamepad_pkg.sv
// Shared constants for the Gamepad PMOD receiver.
// Button indices follow the order the controller shifts them out.
package gamepad_pkg;

    localparam int DEF_NUM_BITS = 12;

    typedef enum logic [3:0] {
        BTN_R      = 4'd0,
        BTN_L      = 4'd1,
        BTN_X      = 4'd2,
        BTN_A      = 4'd3,
        BTN_RIGHT  = 4'd4,
        BTN_LEFT   = 4'd5,
        BTN_DOWN   = 4'd6,
        BTN_UP     = 4'd7,
        BTN_START  = 4'd8,
        BTN_SELECT = 4'd9,
        BTN_Y      = 4'd10,
        BTN_B      = 4'd11
    } btn_e;

endpackage

// File: rtl/sync_rise.sv
// Multi-flop synchroniser with a registered rising-edge pulse.
// rise is high for exactly one cycle, one cycle after sync goes high.
module sync_rise #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic sync,
    output logic rise
);

    logic [STAGES-1:0] chain;
    logic              prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
            prev  <= 1'b0;
            rise  <= 1'b0;
        end else begin
            chain <= {chain[STAGES-2:0], din};
            prev  <= chain[STAGES-1];
            rise  <= chain[STAGES-1] & ~prev;
        end
    end

    assign sync = chain[STAGES-1];

endmodule

// File: rtl/gamepad_pmod_decoder.sv
// Gamepad PMOD serial receiver: synchronises latch/clock/data, shifts
// in one frame per latch and tracks controller presence with a timeout.
module gamepad_pmod_decoder
    import gamepad_pkg::*;
#(
    parameter int NUM_BITS    = DEF_NUM_BITS,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1048575
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pmod_data,
    input  logic                pmod_clk,
    input  logic                pmod_latch,
    output logic [NUM_BITS-1:0] buttons,
    output logic                valid,
    output logic                frame_err,
    output logic                is_present
);

    localparam int CW = $clog2(NUM_BITS + 2);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [CW-1:0] CNT_FULL = CW'(NUM_BITS);
    localparam logic [CW-1:0] CNT_SAT  = CW'(NUM_BITS + 1);
    localparam logic [TW-1:0] RELOAD   = TW'(TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST = TW'(1);

    logic                   clk_sync;
    logic                   clk_rise;
    logic                   latch_sync;
    logic                   latch_rise;
    logic [SYNC_STAGES-1:0] data_chain;
    logic                   data_sync;
    logic [NUM_BITS-1:0]    shreg;
    logic [CW-1:0]          bit_cnt;
    logic [TW-1:0]          tmo;
    logic                   unused_sync;

    sync_rise #(.STAGES(SYNC_STAGES)) u_clk_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (pmod_clk),
        .sync  (clk_sync),
        .rise  (clk_rise)
    );

    sync_rise #(.STAGES(SYNC_STAGES)) u_latch_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (pmod_latch),
        .sync  (latch_sync),
        .rise  (latch_rise)
    );

    assign unused_sync = clk_sync ^ latch_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_chain <= '0;
        end else begin
            data_chain <= {data_chain[SYNC_STAGES-2:0], pmod_data};
        end
    end

    assign data_sync = data_chain[SYNC_STAGES-1];

    // A latch edge overrides a coincident clock edge; later assignments win.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buttons    <= '0;
            valid      <= 1'b0;
            frame_err  <= 1'b0;
            is_present <= 1'b0;
            shreg      <= '0;
            bit_cnt    <= '0;
            tmo        <= '0;
        end else begin
            valid     <= 1'b0;
            frame_err <= 1'b0;
            if (tmo != '0) begin
                tmo <= tmo - 1'b1;
            end
            if (tmo == TMO_LAST) begin
                is_present <= 1'b0;
                buttons    <= '0;
            end
            if (latch_rise) begin
                bit_cnt <= '0;
                if (bit_cnt == CNT_FULL) begin
                    buttons    <= shreg;
                    valid      <= 1'b1;
                    is_present <= 1'b1;
                    tmo        <= RELOAD;
                end else begin
                    frame_err <= 1'b1;
                end
            end else if (clk_rise) begin
                shreg <= {shreg[NUM_BITS-2:0], ~data_sync};
                if (bit_cnt != CNT_SAT) begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_gamepad_pmod_decoder.sv
// Bench for gamepad_pmod_decoder: table vectors, corner sequences and
// random frames checked against a frame-level model of the receiver.
module tb_gamepad_pmod_decoder;
    import gamepad_pkg::*;

    localparam int NB  = 12;
    localparam int SS  = 2;
    localparam int TO  = 100;
    localparam int LAT = SS + 2;
    localparam int PH  = SS + 1;

    logic          clk        = 1'b0;
    logic          rst_n      = 1'b0;
    logic          pmod_data  = 1'b1;
    logic          pmod_clk   = 1'b0;
    logic          pmod_latch = 1'b0;
    logic [NB-1:0] buttons;
    logic          valid;
    logic          frame_err;
    logic          is_present;

    gamepad_pmod_decoder #(
        .NUM_BITS    (NB),
        .SYNC_STAGES (SS),
        .TIMEOUT     (TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pmod_data  (pmod_data),
        .pmod_clk   (pmod_clk),
        .pmod_latch (pmod_latch),
        .buttons    (buttons),
        .valid      (valid),
        .frame_err  (frame_err),
        .is_present (is_present)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    // Frame-level model: bits received since the last latch, last good frame.
    bit            mq[$];
    logic [NB-1:0] m_btn  = '0;
    int            m_last = 0;
    bit            m_have = 0;

    logic          lv, le, lp;
    logic [NB-1:0] lb;

    typedef struct {
        logic [15:0]   raw;
        int            n;
        logic          v;
        logic          e;
        logic [NB-1:0] btn;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at cycle %0d",
                      name, act, exp, cyc);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [NB-1:0] model_btn(input int c);
        return (m_have && c < m_last + TO) ? m_btn : '0;
    endfunction

    function automatic logic model_pres(input int c);
        return m_have && c < m_last + TO;
    endfunction

    task automatic send_bit(input logic d);
        pmod_clk  = 1'b0;
        pmod_data = d;
        tick(PH);
        pmod_clk  = 1'b1;
        mq.push_back(!d);
        tick(PH);
    endtask

    task automatic send_frame(input logic [15:0] raw, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(raw[i]);
    endtask

    task automatic latch_frame(input bit with_clk);
        bit            good;
        logic [NB-1:0] fb;
        pmod_clk = 1'b0;
        if (with_clk) begin
            tick(PH);
            pmod_clk = 1'b1;
        end
        pmod_latch = 1'b1;
        good = (mq.size() == NB);
        fb = '0;
        if (good) for (int i = 0; i < NB; i++) fb[NB-1-i] = mq[i];
        tick(LAT);
        if (good) begin
            m_btn  = fb;
            m_last = cyc;
            m_have = 1;
        end
        lv = valid;
        le = frame_err;
        lb = buttons;
        lp = is_present;
        check("valid", valid, good);
        check("frame_err", frame_err, !good);
        check("buttons", buttons, model_btn(cyc));
        check("is_present", is_present, model_pres(cyc));
        tick(1);
        check("pulse_width", {valid, frame_err}, 0);
        pmod_latch = 1'b0;
        pmod_clk   = 1'b0;
        mq.delete();
        tick(PH);
    endtask

    initial begin
        int v0, w0, r, n;

        tbl[0] = '{16'h07FE, 12, 1'b1, 1'b0, 12'h801};
        tbl[1] = '{16'h07FF, 11, 1'b0, 1'b1, 12'h801};
        tbl[2] = '{16'h0000, 12, 1'b1, 1'b0, 12'hFFF};
        tbl[3] = '{16'h1FFF, 13, 1'b0, 1'b1, 12'hFFF};
        tbl[4] = '{16'h05A3, 12, 1'b1, 1'b0, 12'hA5C};
        tbl[5] = '{16'h0000,  0, 1'b0, 1'b1, 12'hA5C};
        tbl[6] = '{16'h0FFF, 12, 1'b1, 1'b0, 12'h000};
        tbl[7] = '{16'h05A3, 12, 1'b1, 1'b0, 12'hA5C};

        tick(3);
        check("rst_buttons", buttons, 0);
        check("rst_valid", valid, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_present", is_present, 0);
        rst_n = 1'b1;
        tick(PH);

        for (int i = 0; i < 8; i++) begin
            send_frame(tbl[i].raw, tbl[i].n);
            latch_frame(0);
            check("tbl_valid", lv, tbl[i].v);
            check("tbl_err", le, tbl[i].e);
            check("tbl_buttons", lb, tbl[i].btn);
            check("tbl_present", lp, 1);
        end
        check("b_r_pressed", tbl[0].btn,
              (12'(1) << BTN_B) | (12'(1) << BTN_R));

        // Presence drops exactly TO cycles after the last valid pulse.
        v0 = m_last;
        while (cyc < v0 + TO - 1) tick(1);
        check("to_present_before", is_present, 1);
        check("to_buttons_before", buttons, 12'hA5C);
        tick(1);
        check("to_present_after", is_present, 0);
        check("to_buttons_after", buttons, 0);

        // A valid frame landing on the expiry cycle keeps presence.
        send_frame(16'h07FE, 12);
        latch_frame(0);
        w0 = m_last;
        send_frame(16'($urandom), 12);
        while (cyc < w0 + TO - LAT) tick(1);
        latch_frame(0);
        check("boundary_valid", lv, 1);
        check("boundary_present", lp, 1);
        check("boundary_present_later", is_present, 1);
        tick(30);
        check("boundary_present_held", is_present, 1);

        // Clock and latch edges together: latch wins, no 13th shift.
        send_frame(16'h03C5, 12);
        latch_frame(1);
        check("simul_valid", lv, 1);
        check("simul_buttons", lb, 12'hC3A);

        // Asynchronous reset in the middle of a frame.
        send_frame(16'h07FE, 12);
        latch_frame(0);
        send_frame(16'h0015, 6);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_buttons", buttons, 0);
        check("mid_rst_valid", valid, 0);
        check("mid_rst_err", frame_err, 0);
        check("mid_rst_present", is_present, 0);
        m_have = 0;
        mq.delete();
        pmod_clk  = 1'b0;
        pmod_data = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(PH);
        send_frame(16'h07FE, 12);
        latch_frame(0);
        check("post_rst_buttons", lb, 12'h801);

        for (int k = 0; k < 24; k++) begin
            r = $urandom_range(0, 5);
            n = (r == 0) ? 11 : (r == 1) ? 13 : 12;
            tick($urandom_range(0, 30));
            send_frame(16'($urandom), n);
            latch_frame(0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
